mc_arb_wrr: RTL

MC_ARB_WRR -- requirements
Module: mc_arb_wrr

---
 rtl/mc_arb_wrr.sv | 103 ++++++++++
 1 files changed

// File: rtl/mc_arb_wrr.sv
// mc_arb_wrr: three-class (urgent/high/normal) round-robin arbiter with per-port
// starvation counters, registered one-hot grant and a freeze (hold) input.
`default_nettype none

module mc_arb_wrr #(
  parameter real TCQ       = 0.1,
  parameter int  NPORT     = 4,
  parameter int  WAIT_W    = 4,
  parameter int  STARVE_TH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORT-1:0]         req,
  input  logic [NPORT-1:0]         prio,
  input  logic                     hold,
  output logic [NPORT-1:0]         winPort,
  output logic [$clog2(NPORT)-1:0] winIdx,
  output logic                     winVld
);

  localparam int                IDX_W  = $clog2(NPORT);
  localparam logic [WAIT_W-1:0] TH     = WAIT_W'(STARVE_TH);
  localparam logic [IDX_W-1:0]  PTR_RST = IDX_W'(NPORT - 1);

  logic [NPORT-1:0]  win_q;
  logic [IDX_W-1:0]  idx_q;
  logic              vld_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [WAIT_W-1:0] cnt_q [NPORT];
  logic [WAIT_W-1:0] cnt_d [NPORT];

  logic [NPORT-1:0]  urg;
  logic [NPORT-1:0]  hi;
  logic [NPORT-1:0]  nrm;
  logic [NPORT-1:0]  cand;
  logic [NPORT-1:0]  grant_d;
  logic [IDX_W-1:0]  idx_d;
  logic              found;

  always_comb begin
    urg     = '0;
    hi      = '0;
    nrm     = '0;
    cand    = '0;
    grant_d = '0;
    idx_d   = '0;
    found   = 1'b0;

    for (int i = 0; i < NPORT; i++) begin
      urg[i] = req[i] && (cnt_q[i] == TH);
      hi[i]  = req[i] && prio[i] && !urg[i];
      nrm[i] = req[i] && !prio[i] && !urg[i];
    end

    // Only the highest non-empty class competes.
    if (|urg)     cand = urg;
    else if (|hi) cand = hi;
    else          cand = nrm;

    for (int k = 1; k <= NPORT; k++) begin
      int               pos;
      logic [IDX_W-1:0] pos_idx;
      pos = int'(ptr_q) + k;
      if (pos >= NPORT) pos = pos - NPORT;
      pos_idx = IDX_W'(pos);
      if (!found && cand[pos_idx]) begin
        found = 1'b1;
        idx_d = pos_idx;
      end
    end

    if (found) grant_d[idx_d] = 1'b1;

    for (int i = 0; i < NPORT; i++) begin
      if (!req[i] || grant_d[i]) cnt_d[i] = '0;
      else if (cnt_q[i] != TH)   cnt_d[i] = cnt_q[i] + 1'b1;
      else                       cnt_d[i] = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
      ptr_q <= PTR_RST;
      for (int i = 0; i < NPORT; i++) cnt_q[i] <= '0;
    end else if (!hold) begin
      win_q <= grant_d;
      idx_q <= idx_d;
      vld_q <= found;
      if (found) ptr_q <= idx_d;
      for (int i = 0; i < NPORT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign winPort = win_q;
  assign winIdx  = idx_q;
  assign winVld  = vld_q;

endmodule

`default_nettype wire
